// File: rtl/panel_matrix_responder.sv
// Panel-side end of the front-panel lamp/switch matrix: rebuilds the lamp frame and answers switch-row strobes.
// Optional feature macro: PANEL_DECAY_EN (lamps held lit until off in two consecutive committed frames).
module panel_matrix_responder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4000000,
  parameter int CNT_W   = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  led_row,
  input  logic [2:0]  sw_row_n,
  input  logic [11:0] col_i,
  output logic [11:0] col_o,
  output logic [11:0] col_oe,
  input  logic [11:0] sr,
  input  logic [2:0]  dfsr,
  input  logic [2:0]  ifsr,
  input  logic [7:0]  keys,
  output logic [95:0] led_frame,
  output logic        frame_stb,
  output logic        frame_err,
  output logic        link_ok,
  output logic [1:0]  fsm_state
);

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(TIMEOUT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STABLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [7:0]  led_row_m, led_row_s;
  logic [2:0]  sw_row_n_m, sw_row_n_s;
  logic [11:0] col_i_m, col_i_s;
  logic [11:0] sr_m, sr_s;
  logic [2:0]  dfsr_m, dfsr_s;
  logic [2:0]  ifsr_m, ifsr_s;
  logic [7:0]  keys_m, keys_s;

  logic [1:0]       state;
  logic [7:0]       row_q;
  logic [2:0]       row_idx;
  logic [SET_W-1:0] cnt;
  logic [95:0]      row_buf;
  logic [95:0]      next_buf;
  logic [6:0]       row_seen;
  logic [CNT_W-1:0] tcnt;
  logic             conflict_q;

  logic [2:0]  led_idx;
  logic        led_onehot;
  logic        led_bad;
  logic [2:0]  sw_low;
  logic        sw_one;
  logic        sw_multi;
  logic        strobe_clash;
  logic        conflict;
  logic        conflict_rise;
  logic        capture;
  logic        last_row;
  logic        commit;
  logic        discard;
  logic        drive;
  logic [11:0] sw_pat;

  assign col_o     = '0;
  assign fsm_state = state;

  // Synchronisers; the switch strobes rest at their idle (all high) value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_row_m  <= '0;
      led_row_s  <= '0;
      sw_row_n_m <= '1;
      sw_row_n_s <= '1;
      col_i_m    <= '0;
      col_i_s    <= '0;
      sr_m       <= '0;
      sr_s       <= '0;
      dfsr_m     <= '0;
      dfsr_s     <= '0;
      ifsr_m     <= '0;
      ifsr_s     <= '0;
      keys_m     <= '0;
      keys_s     <= '0;
    end else begin
      led_row_m  <= led_row;
      led_row_s  <= led_row_m;
      sw_row_n_m <= sw_row_n;
      sw_row_n_s <= sw_row_n_m;
      col_i_m    <= col_i;
      col_i_s    <= col_i_m;
      sr_m       <= sr;
      sr_s       <= sr_m;
      dfsr_m     <= dfsr;
      dfsr_s     <= dfsr_m;
      ifsr_m     <= ifsr;
      ifsr_s     <= ifsr_m;
      keys_m     <= keys;
      keys_s     <= keys_m;
    end
  end

  always_comb begin
    led_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (led_row_s[i]) led_idx = 3'(i);
    end
  end

  assign led_onehot    = (led_row_s != 8'd0) && ((led_row_s & (led_row_s - 8'd1)) == 8'd0);
  assign led_bad       = (led_row_s != 8'd0) && !led_onehot;
  assign sw_low        = ~sw_row_n_s;
  assign sw_one        = (sw_low != 3'd0) && ((sw_low & (sw_low - 3'd1)) == 3'd0);
  assign sw_multi      = (sw_low != 3'd0) && !sw_one;
  assign strobe_clash  = (led_row_s != 8'd0) && (sw_low != 3'd0);
  assign conflict      = led_bad || sw_multi || strobe_clash;
  assign conflict_rise = conflict && !conflict_q;

  // A capture needs a clean strobe, so commit/discard never coincide with a conflict pulse.
  assign capture  = (state == ST_STABLE) && !conflict && (led_row_s == row_q) &&
                    (cnt == SET_W'(SETTLE));
  assign last_row = (row_idx == 3'd7);
  assign commit   = capture && last_row && (&row_seen);
  assign discard  = capture && last_row && !(&row_seen);

  always_comb begin
    next_buf = row_buf;
    next_buf[12*row_idx +: 12] = ~col_i_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      row_q   <= '0;
      row_idx <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (led_onehot && (sw_row_n_s == 3'b111)) begin
            state   <= ST_STABLE;
            row_q   <= led_row_s;
            row_idx <= led_idx;
            cnt     <= SET_W'(1);
          end
        end
        ST_STABLE: begin
          if (conflict || (led_row_s != row_q)) state <= ST_IDLE;
          else if (cnt == SET_W'(SETTLE))      state <= ST_HOLD;
          else                                   cnt   <= cnt + 1'b1;
        end
        ST_HOLD: begin
          if (conflict || (led_row_s != row_q)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_buf  <= '0;
      row_seen <= '0;
    end else if (capture) begin
      row_buf <= next_buf;
      if (last_row) begin
        row_seen <= '0;
      end else begin
        for (int i = 0; i < 7; i++) begin
          if (row_idx == 3'(i)) row_seen[i] <= 1'b1;
        end
      end
    end
  end

`ifdef PANEL_DECAY_EN
  // off_once marks a lit lamp that has read off in exactly one committed frame.
  logic [95:0] off_once;
  logic [95:0] off_next;

  assign off_next = ~next_buf & led_frame & ~off_once;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_frame <= '0;
      off_once  <= '0;
    end else if (commit) begin
      led_frame <= next_buf | off_next;
      off_once  <= off_next;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_frame <= '0;
    end else if (commit) begin
      led_frame <= next_buf;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_stb  <= 1'b0;
      frame_err  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      frame_stb  <= commit;
      frame_err  <= discard || conflict_rise;
      conflict_q <= conflict;
    end
  end

  assign drive = sw_one && (led_row_s == 8'd0);

  always_comb begin
    case (sw_row_n_s)
      3'b110:  sw_pat = sr_s;
      3'b101:  sw_pat = {dfsr_s, ifsr_s, 6'b0};
      3'b011:  sw_pat = {keys_s, 4'b0};
      default: sw_pat = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_oe <= '0;
    end else begin
      col_oe <= drive ? sw_pat : 12'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt    <= '0;
      link_ok <= 1'b0;
    end else if (commit) begin
      tcnt    <= '0;
      link_ok <= 1'b1;
    end else if (tcnt != T_MAX) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      link_ok <= 1'b0;
    end
  end

endmodule

// File: tb/tb_panel_matrix_responder.sv
// Bench for panel_matrix_responder: directed scans, switch responses, conflicts, random scans and link timeout.
module tb_panel_matrix_responder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  led_row;
  logic [2:0]  sw_row_n;
  logic [11:0] col_i;
  logic [11:0] col_o;
  logic [11:0] col_oe;
  logic [11:0] sr;
  logic [2:0]  dfsr;
  logic [2:0]  ifsr;
  logic [7:0]  keys;
  logic [95:0] led_frame;
  logic        frame_stb;
  logic        frame_err;
  logic        link_ok;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int exp_stb = 0;
  int exp_err = 0;

  logic [11:0] mdl_buf [8];
  bit          mdl_seen [8];
  int          off_run [96];
  logic [95:0] exp_frame;

  panel_matrix_responder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .CNT_W(22)) dut (
    .clk(clk), .rst(rst), .led_row(led_row), .sw_row_n(sw_row_n), .col_i(col_i),
    .col_o(col_o), .col_oe(col_oe), .sr(sr), .dfsr(dfsr), .ifsr(ifsr), .keys(keys),
    .led_frame(led_frame), .frame_stb(frame_stb), .frame_err(frame_err),
    .link_ok(link_ok), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_stb) stb_cnt++;
    if (frame_err) err_cnt++;
    if (frame_stb && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) begin
      mdl_buf[r]  = '0;
      mdl_seen[r] = 1'b0;
    end
    for (int i = 0; i < 96; i++) off_run[i] = 2;
    exp_frame = '0;
  endtask

  // Each lamp tracks how many committed frames in a row it has read off.
  task automatic model_commit();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 12; c++) begin
        if (mdl_buf[r][c]) off_run[12*r+c] = 0;
        else if (off_run[12*r+c] < 2) off_run[12*r+c]++;
`ifdef PANEL_DECAY_EN
        exp_frame[12*r+c] = (off_run[12*r+c] < 2);
`else
        exp_frame[12*r+c] = (off_run[12*r+c] == 0);
`endif
      end
    end
    exp_stb++;
  endtask

  task automatic scan_row(input int r, input logic [11:0] lit, input int hold);
    bit all_seen;
    led_row = 8'(1 << r);
    col_i   = ~lit;
    repeat (hold) @(negedge clk);
    led_row = '0;
    col_i   = 12'($urandom);
    repeat (2) @(negedge clk);
    if (hold >= SETTLE + 2) begin
      mdl_buf[r] = lit;
      if (r == 7) begin
        all_seen = 1'b1;
        for (int i = 0; i < 7; i++) if (!mdl_seen[i]) all_seen = 1'b0;
        if (all_seen) model_commit();
        else exp_err++;
        for (int i = 0; i < 8; i++) mdl_seen[i] = 1'b0;
      end else begin
        mdl_seen[r] = 1'b1;
      end
    end
  endtask

  task automatic full_scan(input bit rnd);
    for (int r = 0; r < 8; r++) begin
      scan_row(r, rnd ? 12'($urandom) : 12'(12'h101 * r), SETTLE + 2);
    end
  endtask

  task automatic check_frame(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_stb"}, 96'(stb_cnt), 96'(exp_stb));
    check({tag, "_err"}, 96'(err_cnt), 96'(exp_err));
    check({tag, "_frame"}, led_frame, exp_frame);
  endtask

  task automatic sw_check(input string tag, input logic [2:0] pat);
    logic [11:0] expv;
    case (pat)
      3'b110:  expv = sr;
      3'b101:  expv = {dfsr, ifsr, 6'b0};
      3'b011:  expv = {keys, 4'b0};
      default: expv = '0;
    endcase
    sw_row_n = pat;
    repeat (3) @(negedge clk);
    check(tag, 96'(col_oe), 96'(expv));
    sw_row_n = 3'b111;
    repeat (3) @(negedge clk);
    check({tag, "_idle"}, 96'(col_oe), 96'd0);
  endtask

  task automatic conflict_check(input string tag, input logic [7:0] lr, input logic [2:0] sw);
    led_row  = lr;
    sw_row_n = sw;
    repeat (5) @(negedge clk);
    check({tag, "_oe"}, 96'(col_oe), 96'd0);
    led_row  = '0;
    sw_row_n = 3'b111;
    repeat (4) @(negedge clk);
    exp_err++;
    check({tag, "_err"}, 96'(err_cnt), 96'(exp_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame"}, led_frame, 96'd0);
    check({tag, "_oe"}, 96'(col_oe), 96'd0);
    check({tag, "_o"}, 96'(col_o), 96'd0);
    check({tag, "_pulses"}, 96'({frame_stb, frame_err}), 96'd0);
    check({tag, "_link"}, 96'(link_ok), 96'd0);
  endtask

  initial begin
    logic [2:0] sw_pats [3];
    int holds [5];
    int sel;
    sw_pats = '{3'b110, 3'b101, 3'b011};
    holds   = '{2, 3, 6, 7, 8};

    rst = 1'b1;
    led_row = '0;
    sw_row_n = 3'b111;
    col_i = '1;
    sr = '0;
    dfsr = '0;
    ifsr = '0;
    keys = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    full_scan(1'b0);
    check_frame("scan1");
    check("scan1_link", 96'(link_ok), 96'd1);

    // Reset lands while row 3 is settling.
    led_row = 8'h08;
    col_i   = 12'h0f0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    led_row = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    full_scan(1'b1);
    check_frame("post_rst");

    sr = 12'o7070;
    dfsr = 3'b101;
    ifsr = 3'b011;
    keys = 8'h81;
    sw_check("sw_sr", 3'b110);
    sw_check("sw_fields", 3'b101);
    sw_check("sw_keys", 3'b011);

    for (int r = 0; r < 8; r++) begin
      if (r != 4) scan_row(r, 12'($urandom), SETTLE + 2);
    end
    check_frame("skip4");

    sr = 12'hfff;
    keys = 8'hff;
    conflict_check("cf_multi_led", 8'h03, 3'b111);
    conflict_check("cf_multi_sw", 8'h00, 3'b100);
    conflict_check("cf_clash", 8'h01, 3'b110);
    check_frame("post_conflict");

    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
        full_scan(1'b1);
      end else if (sel == 3) begin
        sr   = 12'($urandom);
        dfsr = 3'($urandom);
        ifsr = 3'($urandom);
        keys = 8'($urandom);
        sw_check("rnd_sw", sw_pats[$urandom_range(0, 2)]);
      end else begin
        scan_row(int'($urandom_range(0, 7)), 12'($urandom), holds[$urandom_range(0, 4)]);
      end
      check_frame("rnd");
    end

    full_scan(1'b1);
    check_frame("last");
    repeat (TIMEOUT - 50) @(negedge clk);
    check("link_hold", 96'(link_ok), 96'd1);
    repeat (100) @(negedge clk);
    check("link_drop", 96'(link_ok), 96'd0);
    check("stb_err_overlap", 96'(both_cnt), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
